// File: rtl/led_rr_arbiter.sv
// Round-robin owner of the 4-bit board LEDs with a minimum hold; gnt follows req by 1 cycle, io_led follows gnt by 1 cycle.
// Optional `LED_ARB_IDLE_BLINK_EN` shows a heartbeat on io_led while idle; no backpressure, losing requesters simply wait.
module led_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] led_in,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        io_led,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   last_owner, last_owner_d;
  logic [HW-1:0]   hold_cnt, hold_cnt_d;
  logic [NREQ-1:0] others;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic            owner_req;
  logic            take;
  logic [3:0]      idle_led;

  // In GRANT last_owner is the current owner, so it doubles as the slice select.
  assign others    = req & ~gnt;
  assign owner_req = req[last_owner];
  assign busy      = |gnt;

  always_comb begin : rr_search
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && others[idx]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt;
    last_owner_d = last_owner;
    hold_cnt_d   = hold_cnt;
    take         = 1'b0;
    case (state_q)
      IDLE: begin
        take = win_vld;
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt != '0) begin
          hold_cnt_d = hold_cnt - HW'(1);
        end else begin
          // Expired hold with nobody waiting keeps the grant at hold_cnt=0.
          take = win_vld;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (take) begin
      state_d      = GRANT;
      gnt_d        = {{(NREQ-1){1'b0}}, 1'b1} << win;
      last_owner_d = win;
      hold_cnt_d   = HOLD_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt        <= '0;
      last_owner <= IW'(NREQ - 1);
      hold_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      gnt        <= gnt_d;
      last_owner <= last_owner_d;
      hold_cnt   <= hold_cnt_d;
    end
  end

`ifdef LED_ARB_IDLE_BLINK_EN
  logic [5:0] hb_cnt;

  always_ff @(posedge clk) begin
    if (rst) hb_cnt <= '0;
    else     hb_cnt <= hb_cnt + 6'd1;
  end

  assign idle_led = hb_cnt[5:2];
`else
  assign idle_led = 4'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst)       io_led <= 4'h0;
    else if (busy) io_led <= led_in[4*last_owner +: 4];
    else           io_led <= idle_led;
  end

endmodule
